// File: rtl/elevator_door_ctrl.sv
// rtl/elevator_door_ctrl.sv - elevator door sequencer with anti-pinch reopen and fault latch
// Optional: DOOR_NUDGE_EN adds a slow forced-close NUDGE state instead of faulting at the reopen limit.
module elevator_door_ctrl #(
    parameter int MOVE_CYCLES = 20,
    parameter int HOLD_CYCLES = 50,
    parameter int MAX_REOPEN  = 3,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic arrive,
    input  logic car_moving,
    input  logic open_btn,
    input  logic close_btn,
    input  logic obstruct,
    output logic motor_open,
    output logic motor_close,
    output logic door_closed,
    output logic fault,
    output logic alarm
);

    localparam int RW = $clog2(MAX_REOPEN + 1);
    localparam logic [CNT_W-1:0] MOVE_T  = CNT_W'(MOVE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_CYCLES);
`ifdef DOOR_NUDGE_EN
    localparam logic [CNT_W-1:0] NUDGE_T = CNT_W'(2 * MOVE_CYCLES);
`endif
    localparam logic [RW-1:0]    REOPEN_LAST = RW'(MAX_REOPEN - 1);
    localparam logic [RW-1:0]    REOPEN_SAT  = RW'(MAX_REOPEN);

    typedef enum logic [2:0] {
        S_CLOSED,
        S_OPENING,
        S_OPEN,
        S_CLOSING,
        S_FAULT
`ifdef DOOR_NUDGE_EN
        , S_NUDGE
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [RW-1:0]    reopen_q, reopen_d;
    logic             expire;
    logic             motor_open_d, motor_close_d, door_closed_d, fault_d, alarm_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLOSED;
            timer_q     <= '0;
            reopen_q    <= '0;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            door_closed <= 1'b1;
            fault       <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            reopen_q    <= reopen_d;
            motor_open  <= motor_open_d;
            motor_close <= motor_close_d;
            door_closed <= door_closed_d;
            fault       <= fault_d;
            alarm       <= alarm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        reopen_d = reopen_q;
        expire   = tick && (timer_q == CNT_W'(1));
        if (tick && timer_q != '0) timer_d = timer_q - 1'b1;

        case (state_q)
            S_CLOSED: begin
                if ((arrive || open_btn) && !car_moving) begin
                    state_d  = S_OPENING;
                    timer_d  = MOVE_T;
                    reopen_d = '0;
                end
            end
            S_OPENING: begin
                if (expire) begin
                    state_d = S_OPEN;
                    timer_d = HOLD_T;
                end
            end
            S_OPEN: begin
                if (obstruct || open_btn) begin
                    timer_d = HOLD_T;
                end else if ((close_btn && tick) || expire) begin
                    state_d = S_CLOSING;
                    timer_d = MOVE_T;
                end
            end
            S_CLOSING: begin
                // Obstruction reacts on the next clk edge, independent of tick.
                if (obstruct) begin
                    if (reopen_q == REOPEN_LAST) begin
`ifdef DOOR_NUDGE_EN
                        state_d = S_NUDGE;
                        timer_d = NUDGE_T;
`else
                        state_d = S_FAULT;
                        timer_d = '0;
`endif
                    end else begin
                        state_d = S_OPENING;
                        timer_d = MOVE_T;
                        if (reopen_q != REOPEN_SAT) reopen_d = reopen_q + 1'b1;
                    end
                end else if (open_btn) begin
                    state_d = S_OPENING;
                    timer_d = MOVE_T;
                end else if (expire) begin
                    state_d = S_CLOSED;
                end
            end
`ifdef DOOR_NUDGE_EN
            S_NUDGE: begin
                if (expire) state_d = S_CLOSED;
            end
`endif
            default: begin
                state_d = S_FAULT;
                timer_d = '0;
            end
        endcase

        // A moving car with the door not shut is unsafe in every travel state.
        if (car_moving && state_q != S_CLOSED && state_q != S_FAULT) begin
            state_d = S_FAULT;
            timer_d = '0;
        end
    end

    always_comb begin
        motor_open_d  = 1'b0;
        motor_close_d = 1'b0;
        door_closed_d = 1'b0;
        fault_d       = 1'b0;
        alarm_d       = 1'b0;
        case (state_d)
            S_CLOSED:  door_closed_d = 1'b1;
            S_OPENING: motor_open_d  = 1'b1;
            S_CLOSING: motor_close_d = 1'b1;
            S_FAULT: begin
                fault_d = 1'b1;
                alarm_d = 1'b1;
            end
`ifdef DOOR_NUDGE_EN
            S_NUDGE: begin
                motor_close_d = 1'b1;
                alarm_d       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_elevator_door_ctrl.sv
// tb/tb_elevator_door_ctrl.sv - directed self-checking bench for elevator_door_ctrl
module tb_elevator_door_ctrl;

    logic clk = 1'b0;
    logic rst, tick, arrive, car_moving, open_btn, close_btn, obstruct;
    logic motor_open, motor_close, door_closed, fault, alarm;
    int   errors = 0;
    int   checks = 0;

    // {motor_open, motor_close, door_closed, fault, alarm}
    localparam logic [4:0] O_CLOSED  = 5'b00100;
    localparam logic [4:0] O_OPENING = 5'b10000;
    localparam logic [4:0] O_OPEN    = 5'b00000;
    localparam logic [4:0] O_CLOSING = 5'b01000;
    localparam logic [4:0] O_FAULT   = 5'b00011;
    localparam logic [4:0] O_NUDGE   = 5'b01001;

    always #5 clk = ~clk;

    elevator_door_ctrl #(
        .MOVE_CYCLES(4),
        .HOLD_CYCLES(6),
        .MAX_REOPEN (2),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .arrive     (arrive),
        .car_moving (car_moving),
        .open_btn   (open_btn),
        .close_btn  (close_btn),
        .obstruct   (obstruct),
        .motor_open (motor_open),
        .motor_close(motor_close),
        .door_closed(door_closed),
        .fault      (fault),
        .alarm      (alarm)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = {motor_open, motor_close, door_closed, fault, alarm};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic expect_for(input string tag, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, exp);
            step();
        end
    endtask

    task automatic pulse_arrive();
        arrive = 1'b1;
        step();
        arrive = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; arrive = 1'b0; car_moving = 1'b0;
        open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0;
        do_reset();
        chk("reset", O_CLOSED);

        // Full normal cycle: 4 opening, 6 dwell, 4 closing.
        pulse_arrive();
        expect_for("t1_opening", O_OPENING, 4);
        expect_for("t1_open", O_OPEN, 6);
        expect_for("t1_closing", O_CLOSING, 4);
        chk("t1_closed", O_CLOSED);

        // Arrive and open button while moving are dropped, not queued.
        car_moving = 1'b1;
        pulse_arrive();
        chk("t2_moving_arrive", O_CLOSED);
        open_btn = 1'b1;
        step();
        open_btn = 1'b0;
        chk("t2_moving_btn", O_CLOSED);
        car_moving = 1'b0;
        step();
        chk("t2_not_queued", O_CLOSED);

        // Single obstruction at closing cycle 2 reopens fully.
        pulse_arrive();
        expect_for("t3_opening", O_OPENING, 4);
        expect_for("t3_open", O_OPEN, 6);
        expect_for("t3_closing", O_CLOSING, 2);
        obstruct = 1'b1;
        step();
        obstruct = 1'b0;
        expect_for("t3_reopen", O_OPENING, 4);
        expect_for("t3_dwell", O_OPEN, 6);
        expect_for("t3_reclose", O_CLOSING, 4);
        chk("t3_closed", O_CLOSED);

        // close_btn in OPEN cuts the dwell short.
        pulse_arrive();
        expect_for("t5_opening", O_OPENING, 4);
        close_btn = 1'b1;
        step();
        close_btn = 1'b0;
        expect_for("t5_early_close", O_CLOSING, 4);
        chk("t5_closed", O_CLOSED);

        // close_btn with obstruct holds OPEN; dwell restarts on release.
        pulse_arrive();
        expect_for("t5b_opening", O_OPENING, 4);
        close_btn = 1'b1;
        obstruct  = 1'b1;
        expect_for("t5b_held", O_OPEN, 10);
        close_btn = 1'b0;
        obstruct  = 1'b0;
        expect_for("t5b_reloaded", O_OPEN, 6);
        expect_for("t5b_closing", O_CLOSING, 4);
        chk("t5b_closed", O_CLOSED);

        // Timer only counts on tick.
        pulse_arrive();
        tick = 1'b0;
        expect_for("tk_stall", O_OPENING, 5);
        tick = 1'b1;
        expect_for("tk_resume", O_OPENING, 4);
        chk("tk_open", O_OPEN);

        // Car motion while door open is a fault.
        car_moving = 1'b1;
        step();
        car_moving = 1'b0;
        chk("cm_fault", O_FAULT);
        do_reset();
        chk("cm_reset", O_CLOSED);

        // Reset mid-travel returns straight to closed.
        pulse_arrive();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid", O_CLOSED);
        step();
        chk("rst_mid_after", O_CLOSED);

        // Second obstruction in one stop hits the reopen limit.
        pulse_arrive();
        expect_for("t4_opening", O_OPENING, 4);
        expect_for("t4_open", O_OPEN, 6);
        obstruct = 1'b1;
        step();
        obstruct = 1'b0;
        expect_for("t4_reopen1", O_OPENING, 4);
        expect_for("t4_open2", O_OPEN, 6);
        chk("t4_closing2", O_CLOSING);
        obstruct = 1'b1;
        step();
`ifdef DOOR_NUDGE_EN
        open_btn = 1'b1;
        expect_for("t6_nudge", O_NUDGE, 8);
        open_btn = 1'b0;
        chk("t6_closed", O_CLOSED);
        obstruct = 1'b0;
        step();
        chk("t6_no_fault", O_CLOSED);
`else
        obstruct = 1'b0;
        chk("t4_fault", O_FAULT);
        pulse_arrive();
        chk("t4_arrive_ignored", O_FAULT);
        open_btn = 1'b1;
        step();
        open_btn = 1'b0;
        chk("t4_btn_ignored", O_FAULT);
        expect_for("t4_sticky", O_FAULT, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_reset", O_CLOSED);
        chk("t4_nudge_absent", (O_NUDGE & 5'b00000) | O_CLOSED);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
